// File: rtl/buyruk_getir_tamponu.sv
// Instruction-fetch buffer: one tagged instruction word in front of a
// variable-latency instruction memory with request/accept/response handshake.
module buyruk_getir_tamponu #(
  parameter int unsigned ZAMAN_ASIMI = 64,
  parameter logic [31:0] NOP_BUYRUK  = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] adres_i,
  output logic [31:0] buyruk_o,
  output logic        buyruk_gecerli_o,
  output logic        durdur_o,
  output logic        hizali_degil_o,
  output logic        zaman_asimi_o,
  output logic        bellek_istek_o,
  output logic [31:0] bellek_adres_o,
  input  logic        bellek_kabul_i,
  input  logic        bellek_yanit_i,
  input  logic [31:0] bellek_veri_i
);

  localparam int unsigned SAYAC_W = $clog2(ZAMAN_ASIMI) + 1;
  localparam logic [SAYAC_W-1:0] SAYAC_SON = SAYAC_W'(ZAMAN_ASIMI - 1);
  localparam logic [SAYAC_W-1:0] SAYAC_BIR = SAYAC_W'(1);

  typedef enum logic [1:0] {
    BOS   = 2'd0,
    ISTEK = 2'd1,
    BEKLE = 2'd2
  } durum_t;

  durum_t             durum_reg, durum_next;
  logic [29:0]        etiket_reg, etiket_next;
  logic [31:0]        veri_reg, veri_next;
  logic               gecerli_reg, gecerli_next;
  logic [29:0]        istek_adres_reg, istek_adres_next;
  logic [SAYAC_W-1:0] sayac_reg, sayac_next;
  logic               bellek_istek_reg;
  logic [31:0]        bellek_adres_reg, bellek_adres_next;
  logic               zaman_asimi_reg, zaman_asimi_next;

  logic hizali;
  logic isabet;
  logic adres_eslesir;

  assign hizali        = (adres_i[1:0] == 2'b00);
  assign isabet        = gecerli_reg && (etiket_reg == adres_i[31:2]) && hizali;
  assign adres_eslesir = (istek_adres_reg == adres_i[31:2]);

  // Core-facing outputs are purely combinational so a hit costs no cycle.
  assign buyruk_o         = isabet ? veri_reg : NOP_BUYRUK;
  assign buyruk_gecerli_o = isabet;
  assign durdur_o         = hizali && !isabet;
  assign hizali_degil_o   = !hizali;

  assign bellek_istek_o = bellek_istek_reg;
  assign bellek_adres_o = bellek_adres_reg;
  assign zaman_asimi_o  = zaman_asimi_reg;

  always_comb begin
    durum_next       = durum_reg;
    etiket_next      = etiket_reg;
    veri_next        = veri_reg;
    gecerli_next     = gecerli_reg;
    istek_adres_next = istek_adres_reg;
    sayac_next       = sayac_reg;
    zaman_asimi_next = 1'b0;

    case (durum_reg)
      BOS: begin
        if (hizali && !isabet) begin
          istek_adres_next = adres_i[31:2];
          durum_next       = ISTEK;
        end
      end
      ISTEK: begin
        if (bellek_kabul_i) begin
          sayac_next = '0;
          durum_next = BEKLE;
        end
      end
      BEKLE: begin
        if (sayac_reg != SAYAC_SON) begin
          sayac_next = sayac_reg + SAYAC_BIR;
        end
        // A response for a PC the core has already left is dropped; BOS re-misses.
        if (bellek_yanit_i) begin
          if (adres_eslesir) begin
            etiket_next  = istek_adres_reg;
            veri_next    = bellek_veri_i;
            gecerli_next = 1'b1;
          end
          durum_next = BOS;
        end else if (sayac_reg == SAYAC_SON) begin
          zaman_asimi_next = 1'b1;
          durum_next       = ISTEK;
        end
      end
      default: begin
        durum_next = BOS;
      end
    endcase
  end

  // The request address only moves when a new request is about to be raised,
  // so it stays stable for the whole unaccepted window.
  always_comb begin
    bellek_adres_next = bellek_adres_reg;
    if (durum_next == ISTEK) begin
      bellek_adres_next = {istek_adres_next, 2'b00};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_reg        <= BOS;
      etiket_reg       <= '0;
      veri_reg         <= '0;
      gecerli_reg      <= 1'b0;
      istek_adres_reg  <= '0;
      sayac_reg        <= '0;
      bellek_istek_reg <= 1'b0;
      bellek_adres_reg <= '0;
      zaman_asimi_reg  <= 1'b0;
    end else begin
      durum_reg        <= durum_next;
      etiket_reg       <= etiket_next;
      veri_reg         <= veri_next;
      gecerli_reg      <= gecerli_next;
      istek_adres_reg  <= istek_adres_next;
      sayac_reg        <= sayac_next;
      bellek_istek_reg <= (durum_next == ISTEK);
      bellek_adres_reg <= bellek_adres_next;
      zaman_asimi_reg  <= zaman_asimi_next;
    end
  end

endmodule

// File: tb/tb_buyruk_getir_tamponu.sv
// Directed bench for buyruk_getir_tamponu: request addresses and delivered
// instructions are matched against scoreboard queues.
module tb_buyruk_getir_tamponu;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] adres_i;
  logic [31:0] buyruk_o;
  logic        buyruk_gecerli_o;
  logic        durdur_o;
  logic        hizali_degil_o;
  logic        zaman_asimi_o;
  logic        bellek_istek_o;
  logic [31:0] bellek_adres_o;
  logic        bellek_kabul_i;
  logic        bellek_yanit_i;
  logic [31:0] bellek_veri_i;

  int toplam = 0;
  int gecen  = 0;

  logic [31:0] istek_q[$];
  logic [31:0] veri_q[$];

  logic        onceki_gecerli = 1'b0;
  logic [31:0] onceki_adres   = '0;

  buyruk_getir_tamponu #(
    .ZAMAN_ASIMI(8),
    .NOP_BUYRUK (NOP)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .adres_i         (adres_i),
    .buyruk_o        (buyruk_o),
    .buyruk_gecerli_o(buyruk_gecerli_o),
    .durdur_o        (durdur_o),
    .hizali_degil_o  (hizali_degil_o),
    .zaman_asimi_o   (zaman_asimi_o),
    .bellek_istek_o  (bellek_istek_o),
    .bellek_adres_o  (bellek_adres_o),
    .bellek_kabul_i  (bellek_kabul_i),
    .bellek_yanit_i  (bellek_yanit_i),
    .bellek_veri_i   (bellek_veri_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    toplam++;
    if (gozlenen === beklenen) begin
      gecen++;
    end else begin
      $display("FAIL %s: got %h, expected %h", etiket, gozlenen, beklenen);
    end
  endtask

  task automatic saat();
    @(posedge clk_i);
    #1;
  endtask

  // Request scoreboard: every accepted request must match the next expected address.
  always @(negedge clk_i) begin
    if (bellek_istek_o && bellek_kabul_i) begin
      kontrol("istek_bekleniyor", 32'(istek_q.size() != 0), 32'd1);
      if (istek_q.size() != 0) begin
        kontrol("istek_adres", bellek_adres_o, istek_q.pop_front());
      end
      $display("istek  t=%0t adres=%h", $time, bellek_adres_o);
    end
  end

  // Instruction scoreboard: each new hit must deliver the next expected word.
  always @(negedge clk_i) begin
    if (buyruk_gecerli_o && !(onceki_gecerli && onceki_adres == adres_i)) begin
      kontrol("veri_bekleniyor", 32'(veri_q.size() != 0), 32'd1);
      if (veri_q.size() != 0) begin
        kontrol("veri", buyruk_o, veri_q.pop_front());
      end
      $display("buyruk t=%0t adres=%h veri=%h", $time, adres_i, buyruk_o);
    end
    onceki_gecerli = buyruk_gecerli_o;
    onceki_adres   = adres_i;
  end

  initial begin
    rst_i          = 1'b1;
    adres_i        = '0;
    bellek_kabul_i = 1'b0;
    bellek_yanit_i = 1'b0;
    bellek_veri_i  = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    kontrol("rst_buyruk", buyruk_o, NOP);
    kontrol("rst_gecerli", 32'(buyruk_gecerli_o), 32'd0);
    kontrol("rst_istek", 32'(bellek_istek_o), 32'd0);
    kontrol("rst_badres", bellek_adres_o, 32'h0);
    kontrol("rst_zaman", 32'(zaman_asimi_o), 32'd0);

    // Basic miss, memory accepts immediately and answers one cycle later.
    saat(); rst_i = 1'b0; bellek_kabul_i = 1'b1; adres_i = 32'h0; istek_q.push_back(32'h0);
    @(negedge clk_i);
    kontrol("t1_c0_durdur", 32'(durdur_o), 32'd1);
    kontrol("t1_c0_istek", 32'(bellek_istek_o), 32'd0);
    saat(); @(negedge clk_i);
    kontrol("t1_c1_istek", 32'(bellek_istek_o), 32'd1);
    kontrol("t1_c1_badres", bellek_adres_o, 32'h0);
    kontrol("t1_c1_durdur", 32'(durdur_o), 32'd1);
    saat(); bellek_yanit_i = 1'b1; bellek_veri_i = 32'h0050_0093; veri_q.push_back(32'h0050_0093);
    @(negedge clk_i);
    kontrol("t1_c2_durdur", 32'(durdur_o), 32'd1);
    kontrol("t1_c2_gecerli", 32'(buyruk_gecerli_o), 32'd0);
    saat(); bellek_yanit_i = 1'b0; bellek_veri_i = '0;
    @(negedge clk_i);
    kontrol("t1_c3_buyruk", buyruk_o, 32'h0050_0093);
    kontrol("t1_c3_gecerli", 32'(buyruk_gecerli_o), 32'd1);
    kontrol("t1_c3_durdur", 32'(durdur_o), 32'd0);

    // Hit hold.
    for (int i = 0; i < 10; i++) begin
      saat(); @(negedge clk_i);
      kontrol("t2_buyruk", buyruk_o, 32'h0050_0093);
      kontrol("t2_durdur", 32'(durdur_o), 32'd0);
      kontrol("t2_istek", 32'(bellek_istek_o), 32'd0);
    end

    // Backpressure: four unaccepted cycles, accept on the fifth.
    saat(); bellek_kabul_i = 1'b0; adres_i = 32'h4; istek_q.push_back(32'h4);
    @(negedge clk_i);
    kontrol("t3_durdur", 32'(durdur_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      saat(); @(negedge clk_i);
      kontrol("t3_istek", 32'(bellek_istek_o), 32'd1);
      kontrol("t3_badres", bellek_adres_o, 32'h4);
    end
    saat(); bellek_kabul_i = 1'b1;
    @(negedge clk_i);
    kontrol("t3_kabul_istek", 32'(bellek_istek_o), 32'd1);
    kontrol("t3_kabul_badres", bellek_adres_o, 32'h4);
    saat(); bellek_kabul_i = 1'b0;
    @(negedge clk_i);
    kontrol("t3_bekle_istek", 32'(bellek_istek_o), 32'd0);

    // Redirect during BEKLE: stale response must be dropped.
    saat(); adres_i = 32'h100; bellek_yanit_i = 1'b1; bellek_veri_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    kontrol("t4_bayat_gecerli", 32'(buyruk_gecerli_o), 32'd0);
    kontrol("t4_bayat_durdur", 32'(durdur_o), 32'd1);
    saat(); bellek_yanit_i = 1'b0; bellek_veri_i = '0; istek_q.push_back(32'h100);
    @(negedge clk_i);
    kontrol("t4_bos_gecerli", 32'(buyruk_gecerli_o), 32'd0);
    kontrol("t4_bos_istek", 32'(bellek_istek_o), 32'd0);
    saat(); bellek_kabul_i = 1'b1;
    @(negedge clk_i);
    kontrol("t4_istek", 32'(bellek_istek_o), 32'd1);
    kontrol("t4_badres", bellek_adres_o, 32'h100);
    saat(); bellek_kabul_i = 1'b0; bellek_yanit_i = 1'b1; bellek_veri_i = 32'h00A0_0113;
    veri_q.push_back(32'h00A0_0113);
    @(negedge clk_i);
    kontrol("t4_yanit_gecerli", 32'(buyruk_gecerli_o), 32'd0);
    saat(); bellek_yanit_i = 1'b0; bellek_veri_i = '0;
    @(negedge clk_i);
    kontrol("t4_buyruk", buyruk_o, 32'h00A0_0113);
    kontrol("t4_gecerli", 32'(buyruk_gecerli_o), 32'd1);

    // Timeout after eight silent BEKLE cycles, then reissue.
    saat(); adres_i = 32'h200; bellek_kabul_i = 1'b1; istek_q.push_back(32'h200);
    @(negedge clk_i);
    kontrol("t5_durdur", 32'(durdur_o), 32'd1);
    saat(); @(negedge clk_i);
    kontrol("t5_istek", 32'(bellek_istek_o), 32'd1);
    saat(); bellek_kabul_i = 1'b0;
    @(negedge clk_i);
    kontrol("t5_bekle_zaman", 32'(zaman_asimi_o), 32'd0);
    for (int i = 1; i < 8; i++) begin
      saat(); @(negedge clk_i);
      kontrol("t5_bekle_zaman", 32'(zaman_asimi_o), 32'd0);
      kontrol("t5_bekle_istek", 32'(bellek_istek_o), 32'd0);
    end
    saat(); bellek_yanit_i = 1'b1; bellek_veri_i = 32'hBAD0_BAD0; istek_q.push_back(32'h200);
    @(negedge clk_i);
    kontrol("t5_darbe", 32'(zaman_asimi_o), 32'd1);
    kontrol("t5_yeniden_istek", 32'(bellek_istek_o), 32'd1);
    kontrol("t5_yeniden_badres", bellek_adres_o, 32'h200);
    kontrol("t5_gec_gecerli", 32'(buyruk_gecerli_o), 32'd0);
    saat(); bellek_yanit_i = 1'b0; bellek_veri_i = '0;
    @(negedge clk_i);
    kontrol("t5_darbe_bitti", 32'(zaman_asimi_o), 32'd0);
    kontrol("t5_istek_surer", 32'(bellek_istek_o), 32'd1);
    kontrol("t5_gec_yok", 32'(buyruk_gecerli_o), 32'd0);
    saat(); bellek_kabul_i = 1'b1;
    @(negedge clk_i);
    kontrol("t5_kabul_istek", 32'(bellek_istek_o), 32'd1);
    saat(); bellek_kabul_i = 1'b0; bellek_yanit_i = 1'b1; bellek_veri_i = 32'h00F0_0193;
    veri_q.push_back(32'h00F0_0193);
    @(negedge clk_i);
    saat(); bellek_yanit_i = 1'b0; bellek_veri_i = '0;
    @(negedge clk_i);
    kontrol("t5_buyruk", buyruk_o, 32'h00F0_0193);

    // Misaligned PC: trap indication only, no stall, no request.
    saat(); adres_i = 32'h6;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      kontrol("t6_hizali_degil", 32'(hizali_degil_o), 32'd1);
      kontrol("t6_durdur", 32'(durdur_o), 32'd0);
      kontrol("t6_gecerli", 32'(buyruk_gecerli_o), 32'd0);
      kontrol("t6_buyruk", buyruk_o, NOP);
      kontrol("t6_istek", 32'(bellek_istek_o), 32'd0);
      saat();
    end

    // Reset while waiting: the pending response must be ignored.
    adres_i = 32'h300; bellek_kabul_i = 1'b1; istek_q.push_back(32'h300);
    @(negedge clk_i);
    kontrol("t7_hizali_degil", 32'(hizali_degil_o), 32'd0);
    kontrol("t7_durdur", 32'(durdur_o), 32'd1);
    saat(); @(negedge clk_i);
    kontrol("t7_istek", 32'(bellek_istek_o), 32'd1);
    saat(); bellek_kabul_i = 1'b0; rst_i = 1'b1;
    @(negedge clk_i);
    saat(); rst_i = 1'b0; bellek_yanit_i = 1'b1; bellek_veri_i = 32'h1234_5678;
    istek_q.push_back(32'h300);
    @(negedge clk_i);
    kontrol("t7_rst_istek", 32'(bellek_istek_o), 32'd0);
    kontrol("t7_rst_gecerli", 32'(buyruk_gecerli_o), 32'd0);
    kontrol("t7_rst_buyruk", buyruk_o, NOP);
    saat(); bellek_yanit_i = 1'b0; bellek_veri_i = '0; adres_i = 32'h200;
    @(negedge clk_i);
    kontrol("t7_tutucu_temiz", 32'(buyruk_gecerli_o), 32'd0);
    kontrol("t7_yeniden_istek", 32'(bellek_istek_o), 32'd1);
    kontrol("t7_yeniden_badres", bellek_adres_o, 32'h300);
    saat(); adres_i = 32'h300; bellek_kabul_i = 1'b1;
    @(negedge clk_i);
    saat(); bellek_kabul_i = 1'b0; bellek_yanit_i = 1'b1; bellek_veri_i = 32'h0000_0073;
    veri_q.push_back(32'h0000_0073);
    @(negedge clk_i);
    saat(); bellek_yanit_i = 1'b0; bellek_veri_i = '0;
    @(negedge clk_i);
    kontrol("t7_buyruk", buyruk_o, 32'h0000_0073);
    kontrol("t7_gecerli", 32'(buyruk_gecerli_o), 32'd1);

    saat(); @(negedge clk_i);
    kontrol("istek_q_bos", 32'(istek_q.size()), 32'd0);
    kontrol("veri_q_bos", 32'(veri_q.size()), 32'd0);

    $display("%0d/%0d checks passed", gecen, toplam);
    $finish;
  end

endmodule
